uart_rx_os16: RTL and testbench
===============================

Name: uart_rx_os16

Overview:
UART receive front end with 16x oversampling. It converts the serial `i_uart_rx` pin into parallel bytes plus a one-cycle done strobe, and feeds the byte/done pair consumed by the interface block. It contains its own baud tick generation and replaces the simple receiver in the top-level datapath. It also reports framing and parity errors.

Parameters:
- NB_DATA, 8, data bits per frame.
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in baud.
- OVERSAMPLE, 16, ticks per bit.
- F_RX_PARITY, 2'b00, parity mode: 00 none, 01 even, 10 odd (11 treated as none).
- F_RX_STOP_BITS, 1'b1, 1 = one stop bit checked, 0 = no stop bit.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_rx  in  1  asynchronous serial input; idles high.
- o_rx_data  out  NB_DATA  last correctly received byte; held until the next good frame.
- o_rx_done  out  1  one-cycle pulse when o_rx_data updates.
- o_frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- o_parity_err  out  1  one-cycle pulse on a parity mismatch.
- o_busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset state: o_rx_data=0, o_rx_done=0, o_frame_err=0, o_parity_err=0, o_busy=0, FSM=IDLE.
  - Synchronizer flops reset to 1. Tick and bit counters reset to 0.
- Input synchronizer: two flops on i_rx. All decisions use the second flop. This adds 2 cycles of input latency.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer truncation. Default DIV = 54.
  - Free-running counter 0..DIV-1; tick is a one-cycle pulse when the counter equals DIV-1.
  - The counter is cleared on reset only.
- FSM states: IDLE, START, DATA, PARITY, STOP. A sample counter s (0..15) advances on each tick.
- IDLE: when the synced input is 0 → go to START with s=0.
- START: at the tick where s reaches 7 (mid-bit):
  - synced input still 0 → go to DATA, s=0, bit index=0;
  - synced input is 1 → treat as a glitch, go back to IDLE with no pulse.
- DATA: every 16 ticks (s=15), sample the bit LSB-first into a shift register and increment the bit index.
  - After NB_DATA bits, go to PARITY if parity is enabled.
  - Otherwise go to STOP if F_RX_STOP_BITS=1.
  - Otherwise complete the frame directly.
- PARITY: sample one bit after 16 ticks.
  - Even parity requires XOR(data, bit)=0; odd parity requires it to be 1.
  - Record any mismatch, then go to STOP, or complete the frame if F_RX_STOP_BITS=0.
- STOP: sample after 16 ticks.
  - Sampled 0 → pulse o_frame_err and return to IDLE; o_rx_data is unchanged.
  - Sampled 1 with a parity mismatch → pulse o_parity_err and return to IDLE; o_rx_data is unchanged.
  - Sampled 1 with no error → complete the frame.
- Frame completion: in the cycle after the final sample, o_rx_data is loaded and o_rx_done pulses for exactly 1 cycle. FSM then returns to IDLE.
- Error priority: frame error outranks parity error. Only one of the three pulses fires per frame.
- Return to IDLE happens at the stop-bit mid-point, so a back-to-back start bit is detected with no gap.
- o_busy = (state != IDLE), registered.
- Reset during a frame: everything returns to reset values in the next cycle and the partial byte is discarded. No done or error pulse is produced.
- Idle line held low (break): completes as a frame error, then restarts START detection. No done pulse is produced.

Decomposition:
- Shared package (uart_pkg) holds:
  - state encodings;
  - the parity-mode constants PARITY_NONE/EVEN/ODD;
  - the DIV computation function;
  - the OVERSAMPLE midpoint constant (7).
- One sub-module: uart_baud_tick (params CLK_FREQ, BAUD_RATE, OVERSAMPLE; ports clk, i_rst, o_tick). It is reusable by the transmitter.

Test Plan:
All scenarios use defaults; one bit = 864 clocks.
1. Send 0xA5, 8N1 → o_rx_data=0xA5 with a single o_rx_done pulse about 9.5 bit times (~8208 clocks) after the start edge, and no error pulses.
2. Glitch: i_rx low for 200 clocks then high → no o_rx_done, o_busy falls within 8 ticks, FSM back in IDLE.
3. Frame 0x3C with the stop bit driven 0 → one o_frame_err pulse, no o_rx_done, o_rx_data keeps its previous value.
4. F_RX_PARITY=01, byte 0x07 with parity bit 0 (wrong) → o_parity_err pulses; resend with parity bit 1 → o_rx_done, o_rx_data=0x07.
5. i_rst asserted during data bit 4 of 0xFF → next cycle all outputs 0, no pulses; then frame 0x55 → o_rx_data=0x55.
6. Back-to-back 0x00 then 0xFF with no idle gap → two o_rx_done pulses, about 10 bit times apart, with data 0x00 then 0xFF.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and
// baud divider arithmetic used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;

  // Tick index of the start-bit midpoint at 16x oversampling.
  localparam int unsigned OS_MID = 7;

  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate,
                                           input int unsigned oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle pulse every DIV clocks.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign o_tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_os16.sv
// UART receiver with 16x oversampling, optional parity and stop-bit checking;
// emits a byte with a done strobe, or a framing/parity error strobe.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned CLK_FREQ       = 100000000,
  parameter int unsigned BAUD_RATE      = 115200,
  parameter int unsigned OVERSAMPLE     = 16,
  parameter logic [1:0]  F_RX_PARITY    = 2'b00,
  parameter logic        F_RX_STOP_BITS = 1'b1
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done,
  output logic               o_frame_err,
  output logic               o_parity_err,
  output logic               o_busy
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(NB_DATA) + 1;
  localparam logic [SW-1:0] S_MID  = SW'(OS_MID);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(NB_DATA - 1);
  localparam logic PAR_EN  = (F_RX_PARITY == PARITY_EVEN) || (F_RX_PARITY == PARITY_ODD);
  localparam logic PAR_ODD = (F_RX_PARITY == PARITY_ODD);

  logic               rx_meta, rx_sync, tick;
  rx_state_t          state, state_n;
  logic [SW-1:0]      s, s_n;
  logic [BW-1:0]      bit_idx, bit_n;
  logic [NB_DATA-1:0] shift, shift_n, shift_in, data_n;
  logic               par_bad, par_bad_n, par_mism;
  logic               done_n, ferr_n, perr_n;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_tick (
    .clk   (clk),
    .i_rst (i_rst),
    .o_tick(tick)
  );

  always_ff @(posedge clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
    end
  end

  assign shift_in = {rx_sync, shift[NB_DATA-1:1]};
  // Mismatch = observed parity differs from the required one (0 even, 1 odd).
  assign par_mism = (^shift) ^ rx_sync ^ PAR_ODD;

  always_comb begin
    state_n   = state;
    s_n       = s;
    bit_n     = bit_idx;
    shift_n   = shift;
    par_bad_n = par_bad;
    data_n    = o_rx_data;
    done_n    = 1'b0;
    ferr_n    = 1'b0;
    perr_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_sync) begin
          state_n = ST_START;
          s_n     = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (s == S_MID) begin
            s_n       = '0;
            bit_n     = '0;
            par_bad_n = 1'b0;
            state_n   = rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            s_n = s + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (s == S_LAST) begin
            s_n     = '0;
            shift_n = shift_in;
            bit_n   = bit_idx + BW'(1);
            if (bit_idx == B_LAST) begin
              if (PAR_EN) begin
                state_n = ST_PARITY;
              end else if (F_RX_STOP_BITS) begin
                state_n = ST_STOP;
              end else begin
                state_n = ST_IDLE;
                data_n  = shift_in;
                done_n  = 1'b1;
              end
            end
          end else begin
            s_n = s + SW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          if (s == S_LAST) begin
            s_n = '0;
            if (F_RX_STOP_BITS) begin
              par_bad_n = par_mism;
              state_n   = ST_STOP;
            end else begin
              state_n = ST_IDLE;
              if (par_mism) begin
                perr_n = 1'b1;
              end else begin
                data_n = shift;
                done_n = 1'b1;
              end
            end
          end else begin
            s_n = s + SW'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (s == S_LAST) begin
            s_n     = '0;
            state_n = ST_IDLE;
            if (!rx_sync) begin
              ferr_n = 1'b1;
            end else if (par_bad) begin
              perr_n = 1'b1;
            end else begin
              data_n = shift;
              done_n = 1'b1;
            end
          end else begin
            s_n = s + SW'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      s            <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      par_bad      <= 1'b0;
      o_rx_data    <= '0;
      o_rx_done    <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      state        <= state_n;
      s            <= s_n;
      bit_idx      <= bit_n;
      shift        <= shift_n;
      par_bad      <= par_bad_n;
      o_rx_data    <= data_n;
      o_rx_done    <= done_n;
      o_frame_err  <= ferr_n;
      o_parity_err <= perr_n;
      o_busy       <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: an 8N1 instance and an 8E1 instance driven with
// serial frames; outcomes predicted from the frame contents.
module tb_uart_rx_os16;

  localparam int BIT = 864;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;
  logic [7:0] data0, data1;
  logic       done0, ferr0, perr0, busy0;
  logic       done1, ferr1, perr1, busy1;

  uart_rx_os16 dut (
    .clk(clk), .i_rst(rst), .i_rx(rx0),
    .o_rx_data(data0), .o_rx_done(done0), .o_frame_err(ferr0),
    .o_parity_err(perr0), .o_busy(busy0)
  );

  uart_rx_os16 #(.F_RX_PARITY(2'b01)) dut_p (
    .clk(clk), .i_rst(rst), .i_rx(rx1),
    .o_rx_data(data1), .o_rx_done(done1), .o_frame_err(ferr1),
    .o_parity_err(perr1), .o_busy(busy1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk = 0;
  int pass = 0;

  logic [7:0] dq0[$];
  logic [7:0] dq1[$];
  int         dt0[$];
  int         fe0 = 0, pe0 = 0, fe1 = 0, pe1 = 0;
  logic [7:0] exp_data0 = 8'h00;
  logic [7:0] exp_data1 = 8'h00;

  always @(negedge clk) begin
    if (done0) begin dq0.push_back(data0); dt0.push_back(cyc); end
    if (done1) dq1.push_back(data1);
    if (ferr0) fe0++;
    if (perr0) pe0++;
    if (ferr1) fe1++;
    if (perr1) pe1++;
  end

  typedef enum {K_DONE, K_FERR, K_PERR} kind_t;

  // Outcome of one frame judged from what was put on the wire.
  function automatic kind_t model(input logic [7:0] d, input bit has_par, input bit odd,
                                  input bit pbit, input bit stop_ok);
    int ones;
    if (!stop_ok) return K_FERR;
    ones = $countones(d) + int'(pbit);
    if (has_par && ((ones % 2) != (odd ? 1 : 0))) return K_PERR;
    return K_DONE;
  endfunction

  task automatic drive(input int sel, input logic v, input int n);
    if (sel == 0) rx0 = v; else rx1 = v;
    repeat (n) @(negedge clk);
  endtask

  // A bad stop bit is held low only long enough to be sampled, so the
  // receiver's restarted start detection sees a high line and drops it.
  task automatic send_frame(input int sel, input logic [7:0] d, input bit has_par,
                            input bit pbit, input bit stop_ok, input int idle, output int t0);
    t0 = cyc;
    drive(sel, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(sel, d[i], BIT);
    if (has_par) drive(sel, pbit, BIT);
    if (stop_ok) drive(sel, 1'b1, BIT);
    else begin drive(sel, 1'b0, 500); drive(sel, 1'b1, BIT - 500); end
    if (idle > 0) drive(sel, 1'b1, idle);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1;
    repeat (5) @(negedge clk);
    chk++; if ({data0, done0, ferr0, perr0, busy0} !== 12'h000)
      $display("FAIL reset_outputs_8n1: got %h required 000", {data0, done0, ferr0, perr0, busy0});
    else pass++;
    chk++; if ({data1, done1, ferr1, perr1, busy1} !== 12'h000)
      $display("FAIL reset_outputs_8e1: got %h required 000", {data1, done1, ferr1, perr1, busy1});
    else pass++;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk++; if (busy0 !== 1'b0) $display("FAIL idle_busy: got %b required 0", busy0);
    else pass++;
  endtask

  task automatic test_single();
    int n, f, p, t0, lat;
    n = dq0.size(); f = fe0; p = pe0;
    send_frame(0, 8'hA5, 0, 0, 1, 100, t0);
    exp_data0 = 8'hA5;
    chk++; if (dq0.size() !== n + 1) $display("FAIL a5_done_count: got %0d required %0d", dq0.size() - n, 1);
    else pass++;
    if (dq0.size() == n + 1) begin
      lat = dt0[$] - t0;
      chk++; if (dq0[$] !== 8'hA5) $display("FAIL a5_data: got %h required a5", dq0[$]);
      else pass++;
      chk++; if (lat < 8150 || lat > 8220) $display("FAIL a5_latency: got %0d required 8150..8220", lat);
      else pass++;
    end
    chk++; if (fe0 != f || pe0 != p) $display("FAIL a5_no_error: got fe=%0d pe=%0d required 0 0", fe0 - f, pe0 - p);
    else pass++;
    chk++; if (data0 !== 8'hA5) $display("FAIL a5_held: got %h required a5", data0);
    else pass++;
  endtask

  task automatic test_random_frames();
    int n, t0;
    logic [7:0] d;
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom);
      n = dq0.size();
      send_frame(0, d, 0, 0, 1, int'($urandom_range(20, 400)), t0);
      exp_data0 = d;
      chk++; if (dq0.size() !== n + 1 || data0 !== d)
        $display("FAIL rand_frame_%0d: got n=%0d data=%h required n=1 data=%h", k, dq0.size() - n, data0, d);
      else pass++;
    end
  endtask

  task automatic test_glitch();
    int n, f, p;
    n = dq0.size(); f = fe0; p = pe0;
    drive(0, 1'b0, 200);
    chk++; if (busy0 !== 1'b1) $display("FAIL glitch_busy_rise: got %b required 1", busy0);
    else pass++;
    drive(0, 1'b1, 8 * 54 + 60 - 200);
    chk++; if (busy0 !== 1'b0) $display("FAIL glitch_busy_fall: got %b required 0", busy0);
    else pass++;
    drive(0, 1'b1, 2 * BIT);
    chk++; if (dq0.size() != n || fe0 != f || pe0 != p)
      $display("FAIL glitch_no_pulse: got done=%0d fe=%0d pe=%0d required 0 0 0", dq0.size() - n, fe0 - f, pe0 - p);
    else pass++;
  endtask

  task automatic test_frame_err();
    int n, f, p, t0;
    n = dq0.size(); f = fe0; p = pe0;
    send_frame(0, 8'h3C, 0, 0, 0, 2 * BIT, t0);
    chk++; if (fe0 != f + 1) $display("FAIL ferr_pulse: got %0d required 1", fe0 - f);
    else pass++;
    chk++; if (dq0.size() != n || pe0 != p)
      $display("FAIL ferr_only: got done=%0d pe=%0d required 0 0", dq0.size() - n, pe0 - p);
    else pass++;
    chk++; if (data0 !== exp_data0) $display("FAIL ferr_data_held: got %h required %h", data0, exp_data0);
    else pass++;
  endtask

  task automatic test_break();
    int n, f;
    n = dq0.size(); f = fe0;
    drive(0, 1'b0, 9 * BIT + 650);
    drive(0, 1'b1, 2 * BIT);
    chk++; if (fe0 != f + 1 || dq0.size() != n)
      $display("FAIL break: got fe=%0d done=%0d required 1 0", fe0 - f, dq0.size() - n);
    else pass++;
  endtask

  task automatic test_parity();
    int n, f, p, t0;
    kind_t k;
    logic [7:0] d;
    bit pb, so;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: begin d = 8'h07; pb = 0; so = 1; end
        1: begin d = 8'h07; pb = 1; so = 1; end
        2: begin d = 8'h07; pb = 0; so = 0; end
        default: begin d = 8'($urandom); pb = 1'($urandom); so = ($urandom_range(0, 3) != 0); end
      endcase
      k = model(d, 1, 0, pb, so);
      n = dq1.size(); f = fe1; p = pe1;
      send_frame(1, d, 1, pb, so, so ? 100 : 2 * BIT, t0);
      if (k == K_DONE) exp_data1 = d;
      chk++; if (dq1.size() - n != int'(k == K_DONE) || fe1 - f != int'(k == K_FERR) || pe1 - p != int'(k == K_PERR))
        $display("FAIL parity_frame_%0d: got done=%0d fe=%0d pe=%0d required %0d %0d %0d", i,
                 dq1.size() - n, fe1 - f, pe1 - p, int'(k == K_DONE), int'(k == K_FERR), int'(k == K_PERR));
      else pass++;
      chk++; if (data1 !== exp_data1) $display("FAIL parity_data_%0d: got %h required %h", i, data1, exp_data1);
      else pass++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int n, f, p, t0;
    n = dq0.size(); f = fe0; p = pe0;
    drive(0, 1'b0, BIT);
    drive(0, 1'b1, 4 * BIT + 400);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk++; if ({data0, done0, ferr0, perr0, busy0} !== 12'h000)
      $display("FAIL midreset_outputs: got %h required 000", {data0, done0, ferr0, perr0, busy0});
    else pass++;
    exp_data0 = 8'h00; exp_data1 = 8'h00;
    drive(0, 1'b1, 5 * BIT);
    chk++; if (dq0.size() != n || fe0 != f || pe0 != p)
      $display("FAIL midreset_no_pulse: got done=%0d fe=%0d pe=%0d required 0 0 0", dq0.size() - n, fe0 - f, pe0 - p);
    else pass++;
    send_frame(0, 8'h55, 0, 0, 1, 100, t0);
    exp_data0 = 8'h55;
    chk++; if (dq0.size() != n + 1 || data0 !== 8'h55)
      $display("FAIL midreset_recover: got n=%0d data=%h required 1 55", dq0.size() - n, data0);
    else pass++;
  endtask

  task automatic test_back_to_back();
    int n, t0, t1, gap;
    n = dq0.size();
    send_frame(0, 8'h00, 0, 0, 1, 0, t0);
    send_frame(0, 8'hFF, 0, 0, 1, 100, t1);
    exp_data0 = 8'hFF;
    chk++; if (dq0.size() != n + 2) $display("FAIL b2b_count: got %0d required 2", dq0.size() - n);
    else pass++;
    if (dq0.size() == n + 2) begin
      chk++; if (dq0[n] !== 8'h00 || dq0[n+1] !== 8'hFF)
        $display("FAIL b2b_data: got %h %h required 00 ff", dq0[n], dq0[n+1]);
      else pass++;
      gap = dt0[n+1] - dt0[n];
      chk++; if (gap < 10 * BIT - 60 || gap > 10 * BIT + 60)
        $display("FAIL b2b_spacing: got %0d required %0d +/- 60", gap, 10 * BIT);
      else pass++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_random_frames();
    test_glitch();
    test_frame_err();
    test_break();
    test_parity();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
